// File: rtl/string_match_frame_arbiter.sv
// Two-requester, frame-granular arbiter in front of one shared string matching processor.
// Whole frames are granted round-robin; the match result (or a forced timeout) goes to the owner.
module string_match_frame_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] in0_data,
   input  logic       in0_valid,
   input  logic       in0_last,
   output logic       in0_ready,
   input  logic [7:0] in1_data,
   input  logic       in1_valid,
   input  logic       in1_last,
   output logic       in1_ready,
   output logic       proc_enable,
   output logic [7:0] proc_data,
   output logic       proc_valid,
   output logic       proc_last,
   input  logic [7:0] proc_result,
   input  logic       proc_result_valid,
   output logic       res0_valid,
   output logic       res1_valid,
   output logic       res_match,
   output logic       res_timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {StIdle, StStream, StWait} state_e;

   state_e        r_state;
   logic          r_grant;
   logic          r_rr_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_proc_enable;
   logic [7:0]    r_proc_data;
   logic          r_proc_valid;
   logic          r_proc_last;
   logic          r_res0_valid;
   logic          r_res1_valid;
   logic          r_res_match;
   logic          r_res_timeout;

   logic          w_pick;
   logic          w_sel_valid;
   logic          w_sel_last;
   logic [7:0]    w_sel_data;
   logic          w_accept;
   logic          w_unused_result;

   // Only bit 0 of the processor result carries information.
   assign w_unused_result = ^proc_result[7:1];

   // With both requesting the round-robin pointer decides; otherwise the lone requester wins.
   assign w_pick      = (in0_valid && in1_valid) ? r_rr_ptr : in1_valid;
   assign w_sel_valid = r_grant ? in1_valid : in0_valid;
   assign w_sel_last  = r_grant ? in1_last  : in0_last;
   assign w_sel_data  = r_grant ? in1_data  : in0_data;
   assign w_accept    = (r_state == StStream) && w_sel_valid;

   assign in0_ready   = (r_state == StStream) && !r_grant;
   assign in1_ready   = (r_state == StStream) &&  r_grant;

   assign proc_enable = r_proc_enable;
   assign proc_data   = r_proc_data;
   assign proc_valid  = r_proc_valid;
   assign proc_last   = r_proc_last;
   assign res0_valid  = r_res0_valid;
   assign res1_valid  = r_res1_valid;
   assign res_match   = r_res_match;
   assign res_timeout = r_res_timeout;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= StIdle;
         r_grant       <= 1'b0;
         r_rr_ptr      <= 1'b0;
         r_cnt         <= '0;
         r_proc_enable <= 1'b0;
         r_proc_data   <= '0;
         r_proc_valid  <= 1'b0;
         r_proc_last   <= 1'b0;
         r_res0_valid  <= 1'b0;
         r_res1_valid  <= 1'b0;
         r_res_match   <= 1'b0;
         r_res_timeout <= 1'b0;
      end else begin
         r_res0_valid <= 1'b0;
         r_res1_valid <= 1'b0;
         r_proc_valid <= 1'b0;
         r_proc_last  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (in0_valid || in1_valid) begin
                  r_grant       <= w_pick;
                  r_rr_ptr      <= ~w_pick;
                  r_proc_enable <= 1'b1;
                  r_state       <= StStream;
               end
            end
            StStream: begin
               if (w_accept) begin
                  r_proc_data  <= w_sel_data;
                  r_proc_valid <= 1'b1;
                  r_proc_last  <= w_sel_last;
                  if (w_sel_last) begin
                     r_cnt   <= '0;
                     r_state <= StWait;
                  end
               end
            end
            StWait: begin
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CW'(1);
               end
               // A result arriving in the timeout cycle takes priority over the timeout.
               if (proc_result_valid) begin
                  r_res0_valid  <= !r_grant;
                  r_res1_valid  <= r_grant;
                  r_res_match   <= proc_result[0];
                  r_res_timeout <= 1'b0;
                  r_proc_enable <= 1'b0;
                  r_state       <= StIdle;
               end else if (r_cnt == TO_LAST) begin
                  r_res0_valid  <= !r_grant;
                  r_res1_valid  <= r_grant;
                  r_res_match   <= 1'b0;
                  r_res_timeout <= 1'b1;
                  r_proc_enable <= 1'b0;
                  r_state       <= StIdle;
               end
            end
            default: begin
               r_proc_enable <= 1'b0;
               r_state       <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_string_match_frame_arbiter.sv
// Scoreboard bench for string_match_frame_arbiter: drivers stream frames, a model processor
// answers, and a monitor pops expected beats and results whenever the DUT presents them.
module tb_string_match_frame_arbiter;

   localparam int unsigned TO = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in0_data, in1_data;
   logic       in0_valid, in0_last, in0_ready;
   logic       in1_valid, in1_last, in1_ready;
   logic       proc_enable, proc_valid, proc_last;
   logic [7:0] proc_data;
   logic [7:0] proc_result;
   logic       proc_result_valid;
   logic       res0_valid, res1_valid, res_match, res_timeout;

   typedef struct packed {logic [7:0] data; logic last;} beat_t;
   typedef struct packed {logic port; logic match; logic tmo;} res_t;

   beat_t      exp_beat[$];
   res_t       exp_res[$];
   int         n_chk = 0;
   int         n_pass = 0;
   bit         model_en = 1'b1;
   int         model_delay = 2;
   logic [7:0] model_val = 8'h01;
   bit         r1_busy = 1'b0;
   bit         check_gap = 1'b0;
   int         gap_cnt = 0;

   string_match_frame_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .in0_data(in0_data), .in0_valid(in0_valid), .in0_last(in0_last), .in0_ready(in0_ready),
      .in1_data(in1_data), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
      .proc_enable(proc_enable), .proc_data(proc_data), .proc_valid(proc_valid),
      .proc_last(proc_last), .proc_result(proc_result), .proc_result_valid(proc_result_valid),
      .res0_valid(res0_valid), .res1_valid(res1_valid), .res_match(res_match),
      .res_timeout(res_timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   function automatic logic [31:0] outs();
      return {15'd0, in0_ready, in1_ready, proc_enable, proc_data, proc_valid, proc_last,
              res0_valid, res1_valid, res_match, res_timeout};
   endfunction

   function automatic logic rdy(input int port);
      return (port != 0) ? in1_ready : in0_ready;
   endfunction

   task automatic drive(input int port, input logic v, input logic [7:0] d, input logic l);
      if (port == 0) begin
         in0_valid = v; in0_data = d; in0_last = l;
      end else begin
         in1_valid = v; in1_data = d; in1_last = l;
      end
   endtask

   task automatic push_beat(input logic [7:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      exp_beat.push_back(b);
   endtask

   task automatic push_frame(input string s);
      for (int i = 0; i < s.len(); i++) push_beat(s[i], i == s.len() - 1);
   endtask

   task automatic push_res(input logic port, input logic match, input logic tmo);
      res_t r;
      r.port = port; r.match = match; r.tmo = tmo;
      exp_res.push_back(r);
   endtask

   // Returns on the posedge that accepts the final byte; inputs stay driven for the caller.
   task automatic send_frame(input int port, input string s, input bit bubble);
      int         i = 0;
      int         pend = 0;
      int         guard = 0;
      logic [7:0] pb = '0;
      bit         tog = 1'b1;
      bit         v;
      while (i < s.len()) begin
         @(negedge clock);
         if (pend == 1) check("proc_latency", {proc_valid, proc_data}, {1'b1, pb});
         else if (pend == 2) check("proc_bubble", {31'd0, proc_valid}, 0);
         pend = 0;
         v = bubble ? tog : 1'b1;
         tog = ~tog;
         drive(port, v, s[i], i == s.len() - 1);
         if (rdy(port)) begin
            if (v) begin
               pb = s[i]; pend = 1; i++;
            end else begin
               pend = 2;
            end
         end
         guard++;
         if (guard > 500) begin
            check("send_bound", 0, 1);
            break;
         end
      end
      @(posedge clock);
   endtask

   // Called right after send_frame: the next negedge is the first WAIT cycle.
   task automatic timed_result(input logic port, input logic tmo);
      @(negedge clock);
      drive(port, 1'b0, 8'h00, 1'b0);
      check("wait_entry_last", {31'd0, proc_last}, 1);
      repeat (TO - 1) begin
         @(negedge clock);
         check("strobe_early", {30'd0, res1_valid, res0_valid}, 0);
      end
      @(negedge clock);
      check("strobe_at_limit", {29'd0, res1_valid, res0_valid, res_timeout}, {29'd0, port, ~port, tmo});
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_beat.size() != 0 || exp_res.size() != 0) && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("drain", {31'd0, n < 300}, 1);
      repeat (3) @(negedge clock);
   endtask

   // Model processor: answers model_delay cycles after seeing the last byte.
   initial begin
      proc_result = '0;
      proc_result_valid = 1'b0;
      forever begin
         @(negedge clock);
         if (model_en && !reset && proc_valid && proc_last) begin
            repeat (model_delay) @(negedge clock);
            proc_result = model_val;
            proc_result_valid = 1'b1;
            @(negedge clock);
            proc_result_valid = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (proc_valid) begin
            if (exp_beat.size() == 0) check("beat_unexpected", {24'd0, proc_data}, 32'hffff_ffff);
            else begin
               beat_t e;
               e = exp_beat.pop_front();
               check("beat", {23'd0, proc_data, proc_last}, {23'd0, e.data, e.last});
            end
         end
         if (res0_valid || res1_valid) begin
            if (exp_res.size() == 0) check("res_unexpected", 1, 0);
            else begin
               res_t r;
               r = exp_res.pop_front();
               check("result", {28'd0, res1_valid, res0_valid, res_match, res_timeout},
                     {28'd0, r.port, ~r.port, r.match, r.tmo});
            end
         end
         if (r1_busy) check("r0_ready_blocked", {31'd0, in0_ready}, 0);
         if (check_gap) begin
            if (!proc_enable) gap_cnt++;
            else begin
               if (gap_cnt != 0) check("idle_gap", gap_cnt, 1);
               gap_cnt = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clock);
      check("reset_outputs", outs(), 0);
      @(negedge clock);
      reset = 1'b0;

      // Single frame, match found
      push_frame("helloxxhelloy");
      push_res(1'b0, 1'b1, 1'b0);
      send_frame(0, "helloxxhelloy", 1'b0);
      @(negedge clock);
      drive(0, 1'b0, 8'h00, 1'b0);
      drain();

      // Timeout, then a late result that must be ignored
      model_delay = 12;
      model_val = 8'h01;
      push_frame("abc");
      push_res(1'b0, 1'b0, 1'b1);
      send_frame(0, "abc", 1'b0);
      timed_result(1'b0, 1'b1);
      repeat (10) @(negedge clock);
      check("hold_after_late", {29'd0, proc_enable, res_match, res_timeout}, 3'b001);
      drain();

      // Result 0x00 in the timeout cycle wins over the timeout
      model_delay = 7;
      model_val = 8'h00;
      push_frame("DEF");
      push_res(1'b1, 1'b0, 1'b0);
      send_frame(1, "DEF", 1'b0);
      timed_result(1'b1, 1'b0);
      drain();

      // Requester 1 with bubbles; requester 0 arrives mid-frame and must wait
      model_delay = 1;
      model_val = 8'h01;
      push_frame("bubble");
      push_res(1'b1, 1'b1, 1'b0);
      push_frame("zq");
      push_res(1'b0, 1'b1, 1'b0);
      r1_busy = 1'b1;
      fork
         begin
            send_frame(1, "bubble", 1'b1);
            r1_busy = 1'b0;
            @(negedge clock);
            drive(1, 1'b0, 8'h00, 1'b0);
         end
         begin
            repeat (3) @(negedge clock);
            send_frame(0, "zq", 1'b0);
            @(negedge clock);
            drive(0, 1'b0, 8'h00, 1'b0);
         end
      join
      drain();

      // Asynchronous reset after two bytes of a frame
      push_beat(8'hA0, 1'b0);
      push_beat(8'hA1, 1'b0);
      drive(0, 1'b1, 8'hA0, 1'b0);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!in0_ready && n < 20);
      check("grant_r0", {31'd0, in0_ready}, 1);
      @(negedge clock);
      drive(0, 1'b1, 8'hA1, 1'b0);
      @(negedge clock);
      #2 reset = 1'b1;
      #1 check("reset_async", outs(), 0);
      drive(0, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clock);
      check("reset_held", outs(), 0);
      reset = 1'b0;

      // Round-robin from reset: requester 0 first, then alternate, one idle cycle between
      model_val = 8'h02;
      push_frame("r0a"); push_res(1'b0, 1'b0, 1'b0);
      push_frame("r1a"); push_res(1'b1, 1'b0, 1'b0);
      push_frame("r0b"); push_res(1'b0, 1'b0, 1'b0);
      push_frame("r1b"); push_res(1'b1, 1'b0, 1'b0);
      fork
         begin
            send_frame(0, "r0a", 1'b0);
            send_frame(0, "r0b", 1'b0);
            @(negedge clock);
            drive(0, 1'b0, 8'h00, 1'b0);
         end
         begin
            send_frame(1, "r1a", 1'b0);
            send_frame(1, "r1b", 1'b0);
            @(negedge clock);
            drive(1, 1'b0, 8'h00, 1'b0);
         end
         begin
            repeat (2) @(negedge clock);
            check("rr_first", {30'd0, in1_ready, in0_ready}, 2'b01);
            check_gap = 1'b1;
         end
      join
      drain();
      check_gap = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/string_match_frame_arbiter.md
# string_match_frame_arbiter

Two-requester, frame-granular arbiter and sequencer for one shared `string_matching_processor`. It grants whole frames (needle plus haystack bytes, terminated by `last`) to one requester at a time and drives the processor's byte stream and `enable`. It waits for the single-byte match result, or for a timeout, and routes that result back to the requester that owned the frame. It sits between two upstream byte sources and the processor instance.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent in WAIT before a timeout result is forced. Must be ≥ 2.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `in0_data` / `in1_data`  in  8  requester byte.
- `in0_valid` / `in1_valid`  in  1  byte valid.
- `in0_last` / `in1_last`  in  1  final byte of frame.
- `in0_ready` / `in1_ready`  out  1  byte accepted when valid && ready.
- `proc_enable`  out  1  drives processor `enable`.
- `proc_data`  out  8  drives processor `in_data`.
- `proc_valid`  out  1  drives processor `in_valid`.
- `proc_last`  out  1  drives processor `in_last`.
- `proc_result`  in  8  processor `out_data`; only bit 0 is meaningful.
- `proc_result_valid`  in  1  processor `out_valid`.
- `res0_valid` / `res1_valid`  out  1  one-cycle result strobe to the owning requester.
- `res_match`  out  1  match bit. Shared; qualified by `resN_valid`.
- `res_timeout`  out  1  result was forced by timeout. Shared; qualified by `resN_valid`.

## Operation
- States: IDLE, STREAM, WAIT. `grant` is a 1-bit register naming the owner. `rr_ptr` is a 1-bit register naming the preferred requester.
- **IDLE**
  - No `inN_ready`; `proc_enable` = 0.
  - If `in0_valid` or `in1_valid`:
    - If both are valid, set `grant` = `rr_ptr`. Otherwise set `grant` to the valid requester.
    - Set `rr_ptr` = ~`grant`.
    - Go to STREAM.
  - Request detection uses `valid` only; no byte is consumed in IDLE.
- **STREAM**
  - `inN_ready` = 1 for the granted requester only.
  - `proc_enable` = 1.
  - Each accepted beat is registered onto `proc_data`/`proc_valid`/`proc_last` the next cycle.
  - In cycles with no accepted beat, `proc_valid` = 0 and `proc_last` = 0.
  - An accepted beat with `last` = 1 moves the FSM to WAIT and clears the timeout counter.
- **WAIT**
  - `proc_enable` = 1; no `inN_ready`.
  - Timeout counter increments each cycle. Its width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
  - If `proc_result_valid` = 1:
    - Pulse `res[grant]_valid` next cycle with `res_match` = `proc_result[0]` and `res_timeout` = 0.
    - Go to IDLE.
  - Else, if the counter equals `TIMEOUT_CYCLES-1`:
    - Pulse `res[grant]_valid` next cycle with `res_match` = 0 and `res_timeout` = 1.
    - Go to IDLE.
  - If both happen in the same cycle, the result wins.
- `proc_result_valid` seen outside WAIT is ignored. This covers late results after a timeout.
- `res_match` and `res_timeout` hold their last values until the next result strobe.
- A requester that drops `valid` mid-frame keeps the grant. The FSM stays in STREAM; there is no frame-length limit.

## Timing
- All outputs are registered except `inN_ready`, which decodes from state and `grant`.
- Reset values: state = IDLE, `grant` = 0, `rr_ptr` = 0. All outputs are 0: ready, `proc_*`, `resN_valid`, `res_match`, `res_timeout`.
- Grant latency: valid seen in IDLE at cycle t gives ready high at t+1.
- Byte latency: beat accepted at cycle t appears on `proc_*` at t+1.
- `proc_enable` rises in the cycle STREAM is entered and falls in the cycle after the result or timeout is taken.
- Result strobe: `proc_result_valid` at cycle t gives `resN_valid` at t+1, and the FSM is in IDLE at t+1.
- A new grant can be decided at t+1, with ready at t+2.
- Minimum gap between frames: one IDLE cycle with `proc_enable` = 0.
- Timeout: the strobe fires exactly `TIMEOUT_CYCLES` cycles after the cycle WAIT is entered.
- Asynchronous reset mid-frame: everything clears immediately. Ready drops, and the partial frame is abandoned with no result strobe. Requesters must restart their frames.

## Test plan
- **Single frame.** Requester 0 sends needle "hello" and haystack "xxhelloy", ready held. Expected:
  - `proc_*` mirrors the bytes delayed by 1 cycle.
  - Model processor returns result 0x01.
  - `res0_valid` pulses once with `res_match` = 1 and `res_timeout` = 0; `res1_valid` stays 0.
- **Round-robin.** Both requesters hold valid continuously with 3-byte frames. Expected:
  - Grants alternate 0,1,0,1.
  - Each result strobes only its owner's `resN_valid`.
  - Exactly one IDLE cycle with `proc_enable` = 0 between frames.
- **Timeout.** `TIMEOUT_CYCLES` = 8 and the model never asserts result. Expected:
  - `res0_valid` pulses with `res_timeout` = 1 and `res_match` = 0, 8 cycles after entering WAIT.
  - A result injected later is ignored.
- **Simultaneous result and timeout.** Result 0x00 is given in the timeout cycle. Expected: `res_timeout` = 0 and `res_match` = 0.
- **Bubbles.** Requester 1 toggles valid every other cycle. Expected:
  - Requester 0 never gets ready during the frame.
  - `proc_valid` shows matching gaps.
- **Reset mid-operation.** Assert reset in STREAM after 2 bytes. Expected:
  - All outputs read 0 in the same cycle.
  - After release, requester 0 is preferred first (`rr_ptr` = 0).
